// File: rtl/controle_pkg.sv
// Shared types and encodings for the multicycle control unit and its datapath.
package controle_pkg;

  // Control FSM states
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_JUMP,
    S_BRANCH,
    S_ADDR,
    S_MEM_LD,
    S_WB_LD,
    S_MEM_ST,
    S_HALT,
    S_TRAP
  } estado_t;

  // Instruction classes produced by the opcode classifier
  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_JMP,
    CL_BEQ,
    CL_LD,
    CL_ST,
    CL_HLT,
    CL_ILL
  } classe_t;

  // Opcode constants
  localparam int unsigned OP_JMP = 11;
  localparam int unsigned OP_BEQ = 12;
  localparam int unsigned OP_LD  = 13;
  localparam int unsigned OP_ST  = 14;
  localparam int unsigned OP_HLT = 15;

  // ALU operations used by the control unit itself
  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;

  // ALU B source select
  localparam logic [1:0] ULA_B_REG  = 2'b00;
  localparam logic [1:0] ULA_B_UM   = 2'b01;
  localparam logic [1:0] ULA_B_IMM  = 2'b10;
  localparam logic [1:0] ULA_B_DESL = 2'b11;

  // PC source select
  localparam logic [1:0] FCP_ULA    = 2'b00;
  localparam logic [1:0] FCP_ALUOUT = 2'b01;
  localparam logic [1:0] FCP_SALTO  = 2'b10;

  // Datapath control bundle (ALU operation is kept apart: its width is a parameter)
  typedef struct packed {
    logic       esc_cond_cp;
    logic       esc_cp;
    logic       ula_a;
    logic [1:0] ula_b;
    logic [1:0] fonte_cp;
    logic       esc_ir;
    logic       esc_reg;
    logic       ler_mem;
    logic       esc_mem;
    logic       iou_d;
    logic       mem_para_reg;
  } ctrl_t;

endpackage

// File: rtl/classifica_opcode.sv
// Combinational opcode to instruction-class decode; opcodes >= 16 are illegal.
module classifica_opcode
  import controle_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output classe_t             classe
);

  logic alto;

  // Any bit above the low nibble set means an opcode outside 0..15
  generate
    if (OPCODE_W > 4) begin : g_alto
      assign alto = |opcode[OPCODE_W-1:4];
    end else begin : g_sem_alto
      assign alto = 1'b0;
    end
  endgenerate

  // Class table for the 16 legal opcodes
  always_comb begin
    classe = CL_ILL;
    if (!alto) begin
      case (opcode[3:0])
        4'd0, 4'd1, 4'd3, 4'd4, 4'd5:           classe = CL_R;
        4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:    classe = CL_I;
        4'(OP_JMP):                             classe = CL_JMP;
        4'(OP_BEQ):                             classe = CL_BEQ;
        4'(OP_LD):                              classe = CL_LD;
        4'(OP_ST):                              classe = CL_ST;
        4'(OP_HLT):                             classe = CL_HLT;
        default:                                classe = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with ready handshake,
// halt, illegal-opcode trap and memory-wait timeout.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ULA_OP_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_pronto,
  output logic                EscCondCP,
  output logic                EscCP,
  output logic                ULA_A,
  output logic [1:0]          ULA_B,
  output logic [ULA_OP_W-1:0] ULA_OP,
  output logic [1:0]          FonteCP,
  output logic                EscIR,
  output logic                EscReg,
  output logic                LerMem,
  output logic                EscMem,
  output logic                IouD,
  output logic                MemParaReg,
  output logic                parado,
  output logic                erro_op,
  output logic                erro_mem
);

  // Wait counter must be able to hold MEM_TIMEOUT itself
  localparam int unsigned CNT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TO_ULTIMO = (MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          TO_ATIVO  = (MEM_TIMEOUT != 0);

  estado_t             estado, estado_prox;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    espera, espera_prox, espera_inc;
  logic                erro_op_q, erro_mem_q;
  logic                set_erro_op, set_erro_mem;
  logic                estouro;
  classe_t             classe;
  ctrl_t               ctrl;
  logic [ULA_OP_W-1:0] ula_op;

  classifica_opcode #(
    .OPCODE_W (OPCODE_W)
  ) u_classifica (
    .opcode (opcode),
    .classe (classe)
  );

  // The current wait cycle is the last one allowed without an acknowledge
  assign estouro    = TO_ATIVO && (espera == CNT_W'(TO_ULTIMO));
  assign espera_inc = TO_ATIVO ? (espera + CNT_W'(1)) : '0;

  // State, latched opcode, wait counter and sticky trap flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= S_IDLE;
      op_q       <= '0;
      espera     <= '0;
      erro_op_q  <= 1'b0;
      erro_mem_q <= 1'b0;
    end else begin
      estado <= estado_prox;
      espera <= espera_prox;
      if (estado == S_DECODE) begin
        op_q <= opcode;
      end
      if (set_erro_op) begin
        erro_op_q <= 1'b1;
      end
      if (set_erro_mem) begin
        erro_mem_q <= 1'b1;
      end
    end
  end

  // Next state and per-state datapath controls (FETCH write enables gated by mem_pronto)
  always_comb begin
    estado_prox  = estado;
    espera_prox  = '0;
    set_erro_op  = 1'b0;
    set_erro_mem = 1'b0;
    ctrl         = '0;
    ula_op       = '0;

    case (estado)
      S_IDLE: begin
        estado_prox = S_FETCH;
      end

      S_FETCH: begin
        ctrl.ler_mem  = 1'b1;
        ctrl.iou_d    = 1'b0;
        ctrl.ula_a    = 1'b0;
        ctrl.ula_b    = ULA_B_UM;
        ula_op        = ULA_OP_W'(OP_ADD);
        ctrl.fonte_cp = FCP_ULA;
        ctrl.esc_ir   = mem_pronto;
        ctrl.esc_cp   = mem_pronto;
        if (mem_pronto) begin
          estado_prox = S_DECODE;
        end else if (estouro) begin
          estado_prox  = S_TRAP;
          set_erro_mem = 1'b1;
        end else begin
          espera_prox = espera_inc;
        end
      end

      S_DECODE: begin
        ctrl.ula_a = 1'b0;
        ctrl.ula_b = ULA_B_DESL;
        ula_op     = ULA_OP_W'(OP_ADD);
        case (classe)
          CL_R:    estado_prox = S_EXEC_R;
          CL_I:    estado_prox = S_EXEC_I;
          CL_JMP:  estado_prox = S_JUMP;
          CL_BEQ:  estado_prox = S_BRANCH;
          CL_LD:   estado_prox = S_ADDR;
          CL_ST:   estado_prox = S_ADDR;
          CL_HLT:  estado_prox = S_HALT;
          default: begin
            estado_prox = S_TRAP;
            set_erro_op = 1'b1;
          end
        endcase
      end

      S_EXEC_R: begin
        ctrl.ula_a  = 1'b1;
        ctrl.ula_b  = ULA_B_REG;
        ula_op      = ULA_OP_W'(op_q);
        estado_prox = S_WB_ALU;
      end

      S_EXEC_I: begin
        ctrl.ula_a  = 1'b1;
        ctrl.ula_b  = ULA_B_IMM;
        ula_op      = ULA_OP_W'(op_q);
        estado_prox = S_WB_ALU;
      end

      S_WB_ALU: begin
        ctrl.esc_reg      = 1'b1;
        ctrl.mem_para_reg = 1'b0;
        estado_prox       = S_FETCH;
      end

      S_JUMP: begin
        ctrl.esc_cp   = 1'b1;
        ctrl.fonte_cp = FCP_SALTO;
        estado_prox   = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.ula_a       = 1'b1;
        ctrl.ula_b       = ULA_B_REG;
        ula_op           = ULA_OP_W'(OP_SUB);
        ctrl.esc_cond_cp = 1'b1;
        ctrl.fonte_cp    = FCP_ALUOUT;
        estado_prox      = S_FETCH;
      end

      S_ADDR: begin
        ctrl.ula_a  = 1'b1;
        ctrl.ula_b  = ULA_B_IMM;
        ula_op      = ULA_OP_W'(OP_ADD);
        estado_prox = (op_q == OPCODE_W'(OP_LD)) ? S_MEM_LD : S_MEM_ST;
      end

      S_MEM_LD: begin
        ctrl.ler_mem = 1'b1;
        ctrl.iou_d   = 1'b1;
        if (mem_pronto) begin
          estado_prox = S_WB_LD;
        end else if (estouro) begin
          estado_prox  = S_TRAP;
          set_erro_mem = 1'b1;
        end else begin
          espera_prox = espera_inc;
        end
      end

      S_WB_LD: begin
        ctrl.esc_reg      = 1'b1;
        ctrl.mem_para_reg = 1'b1;
        estado_prox       = S_FETCH;
      end

      S_MEM_ST: begin
        ctrl.esc_mem = 1'b1;
        ctrl.iou_d   = 1'b1;
        if (mem_pronto) begin
          estado_prox = S_FETCH;
        end else if (estouro) begin
          estado_prox  = S_TRAP;
          set_erro_mem = 1'b1;
        end else begin
          espera_prox = espera_inc;
        end
      end

      S_HALT: begin
        estado_prox = S_HALT;
      end

      S_TRAP: begin
        estado_prox = S_TRAP;
      end

      default: begin
        estado_prox = S_IDLE;
      end
    endcase
  end

  // Port mapping of the control bundle
  assign EscCondCP  = ctrl.esc_cond_cp;
  assign EscCP      = ctrl.esc_cp;
  assign ULA_A      = ctrl.ula_a;
  assign ULA_B      = ctrl.ula_b;
  assign ULA_OP     = ula_op;
  assign FonteCP    = ctrl.fonte_cp;
  assign EscIR      = ctrl.esc_ir;
  assign EscReg     = ctrl.esc_reg;
  assign LerMem     = ctrl.ler_mem;
  assign EscMem     = ctrl.esc_mem;
  assign IouD       = ctrl.iou_d;
  assign MemParaReg = ctrl.mem_para_reg;
  assign parado     = (estado == S_HALT);
  assign erro_op    = erro_op_q;
  assign erro_mem   = erro_mem_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-instruction cycle-trace model, CPI table, random programs.
module tb_controle_multiciclo;

  localparam int unsigned OW = 5;
  localparam int unsigned UW = 4;
  localparam int unsigned TO = 4;

  // Phase tags used only for messages
  localparam int F_FETCH = 0, F_DEC = 1, F_EXR = 2, F_EXI = 3, F_WB = 4, F_JMP = 5,
                 F_BEQ = 6, F_ADDR = 7, F_MLD = 8, F_WBLD = 9, F_MST = 10, F_HALT = 11,
                 F_TRAPO = 12, F_TRAPM = 13, F_RST = 14;

  typedef struct packed {
    logic       esc_cond_cp;
    logic       esc_cp;
    logic       ula_a;
    logic [1:0] ula_b;
    logic [3:0] ula_op;
    logic [1:0] fonte_cp;
    logic       esc_ir;
    logic       esc_reg;
    logic       ler_mem;
    logic       esc_mem;
    logic       iou_d;
    logic       mem_para_reg;
    logic       parado;
    logic       erro_op;
    logic       erro_mem;
  } saida_t;

  typedef struct {
    logic          pronto;
    logic [OW-1:0] opc;
    saida_t        esp;
    int            fase;
  } ciclo_t;

  typedef struct {
    logic [OW-1:0] opc;
    int            fw;
    int            mw;
    int            cpi;
  } vet_t;

  logic          clk, rst_n, mem_pronto;
  logic [OW-1:0] opcode;
  logic          EscCondCP, EscCP, ULA_A, EscIR, EscReg, LerMem, EscMem, IouD, MemParaReg;
  logic          parado, erro_op, erro_mem;
  logic [1:0]    ULA_B, FonteCP;
  logic [UW-1:0] ULA_OP;
  saida_t        obs;

  int n_cmp = 0;
  int n_bad = 0;
  ciclo_t q[$];

  controle_multiciclo #(.OPCODE_W(OW), .ULA_OP_W(UW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_pronto(mem_pronto),
    .EscCondCP(EscCondCP), .EscCP(EscCP), .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_OP(ULA_OP),
    .FonteCP(FonteCP), .EscIR(EscIR), .EscReg(EscReg), .LerMem(LerMem), .EscMem(EscMem),
    .IouD(IouD), .MemParaReg(MemParaReg), .parado(parado), .erro_op(erro_op), .erro_mem(erro_mem)
  );

  assign obs = {EscCondCP, EscCP, ULA_A, ULA_B, ULA_OP, FonteCP, EscIR, EscReg,
                LerMem, EscMem, IouD, MemParaReg, parado, erro_op, erro_mem};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic string fase_nome(int f);
    case (f)
      F_FETCH: return "fetch";   F_DEC:   return "decode";  F_EXR:  return "exec_r";
      F_EXI:   return "exec_i";  F_WB:    return "wb_alu";  F_JMP:  return "jump";
      F_BEQ:   return "branch";  F_ADDR:  return "addr";    F_MLD:  return "mem_ld";
      F_WBLD:  return "wb_ld";   F_MST:   return "mem_st";  F_HALT: return "halt";
      F_TRAPO: return "trap_op"; F_TRAPM: return "trap_mem";
      default: return "reset";
    endcase
  endfunction

  // Expected datapath controls, one function per kind of cycle
  function automatic saida_t e_fetch(logic p);
    saida_t s = '0;
    s.ler_mem = 1'b1; s.ula_b = 2'b01; s.esc_ir = p; s.esc_cp = p;
    return s;
  endfunction
  function automatic saida_t e_dec();
    saida_t s = '0;
    s.ula_b = 2'b11;
    return s;
  endfunction
  function automatic saida_t e_exec(logic [OW-1:0] op, logic [1:0] b);
    saida_t s = '0;
    s.ula_a = 1'b1; s.ula_b = b; s.ula_op = op[3:0];
    return s;
  endfunction
  function automatic saida_t e_um(int f);
    saida_t s = '0;
    case (f)
      F_WB:    s.esc_reg = 1'b1;
      F_JMP:   begin s.esc_cp = 1'b1; s.fonte_cp = 2'b10; end
      F_BEQ:   begin s.ula_a = 1'b1; s.ula_op = 4'd1; s.esc_cond_cp = 1'b1; s.fonte_cp = 2'b01; end
      F_ADDR:  begin s.ula_a = 1'b1; s.ula_b = 2'b10; end
      F_MLD:   begin s.ler_mem = 1'b1; s.iou_d = 1'b1; end
      F_WBLD:  begin s.esc_reg = 1'b1; s.mem_para_reg = 1'b1; end
      F_MST:   begin s.esc_mem = 1'b1; s.iou_d = 1'b1; end
      F_HALT:  s.parado = 1'b1;
      F_TRAPO: s.erro_op = 1'b1;
      F_TRAPM: s.erro_mem = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [OW-1:0] r_op();
    return OW'($urandom_range(0, 31));
  endfunction
  function automatic logic r_p();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(logic p, logic [OW-1:0] o, saida_t e, int f);
    ciclo_t c;
    c.pronto = p; c.opc = o; c.esp = e; c.fase = f;
    q.push_back(c);
  endtask

  task automatic push_term(int f, int n);
    for (int i = 0; i < n; i++) push(r_p(), r_op(), e_um(f), f);
  endtask

  // A memory access waits w cycles; TO consecutive waits end in a trap
  task automatic fase_mem(int w, saida_t e_wait, saida_t e_ok, int f, output bit trap);
    trap = 1'b0;
    if (w >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) push(1'b0, r_op(), e_wait, f);
      trap = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(1'b0, r_op(), e_wait, f);
      push(1'b1, r_op(), e_ok, f);
    end
  endtask

  // Reference model: expected cycle trace of one instruction from its class
  task automatic instr(logic [OW-1:0] opc, int fw, int mw, int nterm, output bit fim);
    bit t;
    fim = 1'b0;
    fase_mem(fw, e_fetch(1'b0), e_fetch(1'b1), F_FETCH, t);
    if (t) begin
      push_term(F_TRAPM, nterm); fim = 1'b1;
    end else begin
      push(r_p(), opc, e_dec(), F_DEC);
      if (opc >= 16) begin
        push_term(F_TRAPO, nterm); fim = 1'b1;
      end else if (opc inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5}) begin
        push(r_p(), r_op(), e_exec(opc, 2'b00), F_EXR);
        push(r_p(), r_op(), e_um(F_WB), F_WB);
      end else if (opc inside {[5'd6:5'd10], 5'd2}) begin
        push(r_p(), r_op(), e_exec(opc, 2'b10), F_EXI);
        push(r_p(), r_op(), e_um(F_WB), F_WB);
      end else if (opc == 11) begin
        push(r_p(), r_op(), e_um(F_JMP), F_JMP);
      end else if (opc == 12) begin
        push(r_p(), r_op(), e_um(F_BEQ), F_BEQ);
      end else if (opc == 13 || opc == 14) begin
        push(r_p(), r_op(), e_um(F_ADDR), F_ADDR);
        if (opc == 13) fase_mem(mw, e_um(F_MLD), e_um(F_MLD), F_MLD, t);
        else           fase_mem(mw, e_um(F_MST), e_um(F_MST), F_MST, t);
        if (t) begin
          push_term(F_TRAPM, nterm); fim = 1'b1;
        end else if (opc == 13) begin
          push(r_p(), r_op(), e_um(F_WBLD), F_WBLD);
        end
      end else begin
        push_term(F_HALT, nterm); fim = 1'b1;
      end
    end
  endtask

  task automatic comparar(saida_t esp, int f);
    n_cmp++;
    if (obs !== esp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %05h expected %05h", fase_nome(f), $time, obs, esp);
    end
  endtask

  task automatic run_q();
    ciclo_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_pronto = c.pronto;
      opcode     = c.opc;
      #1;
      comparar(c.esp, c.fase);
    end
  endtask

  // Reset held for n edges; every cycle after the first edge shows all-zero outputs
  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; mem_pronto = 1'b1; opcode = r_op();
      if (i > 0) begin #1; comparar('0, F_RST); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    comparar('0, F_RST);
  endtask

  vet_t tab[9];

  initial begin
    bit fim;
    int idx, ciclos, esperas, orc, r, fw, mw;
    bit inicio, prev_fw, eh_fetch, req;
    logic [OW-1:0] opc;

    rst_n = 1'b0; mem_pronto = 1'b1; opcode = '0;

    tab[0] = '{5'd3,  0, 0, 4};
    tab[1] = '{5'd13, 0, 2, 7};
    tab[2] = '{5'd14, 0, 0, 4};
    tab[3] = '{5'd11, 0, 0, 3};
    tab[4] = '{5'd12, 0, 0, 3};
    tab[5] = '{5'd6,  1, 0, 5};
    tab[6] = '{5'd14, 2, 3, 9};
    tab[7] = '{5'd0,  0, 0, 4};
    tab[8] = '{5'd13, 3, 0, 8};

    // Reset, R-type, load with waits, branch, jump, store, halt
    do_reset(3);
    instr(5'd3, 0, 0, 0, fim);
    instr(5'd13, 0, 2, 0, fim);
    instr(5'd12, 0, 0, 0, fim);
    instr(5'd11, 0, 0, 0, fim);
    instr(5'd14, 1, 1, 0, fim);
    instr(5'd15, 0, 0, 6, fim);
    run_q();

    // Illegal opcode trap held
    do_reset(2);
    instr(5'd17, 0, 0, 100, fim);
    run_q();

    // Fetch timeout
    do_reset(1);
    instr(5'd3, 4, 0, 10, fim);
    run_q();

    // Reset pulse in the middle of a store wait
    do_reset(1);
    push(1'b1, r_op(), e_fetch(1'b1), F_FETCH);
    push(1'b0, 5'd14, e_dec(), F_DEC);
    push(1'b0, r_op(), e_um(F_ADDR), F_ADDR);
    push(1'b0, r_op(), e_um(F_MST), F_MST);
    push(1'b0, r_op(), e_um(F_MST), F_MST);
    run_q();
    do_reset(1);

    // Load-data timeout after a reset
    instr(5'd13, 0, 4, 5, fim);
    run_q();

    // CPI table driven by a memory responder that stalls fw/mw cycles
    do_reset(1);
    idx = 0; ciclos = 0; esperas = 0; orc = 0; inicio = 0; prev_fw = 0;
    while (orc < 400) begin
      @(negedge clk);
      orc++;
      eh_fetch = LerMem && !IouD;
      if (eh_fetch && !prev_fw) begin
        if (inicio) begin
          n_cmp++;
          if (ciclos != tab[idx].cpi) begin
            n_bad++;
            $display("FAIL cpi[%0d] op=%0d: got %0d cycles expected %0d", idx, tab[idx].opc, ciclos, tab[idx].cpi);
          end
          idx++;
        end
        inicio = 1; ciclos = 0; esperas = 0;
      end
      if (idx == 9) break;
      opcode = tab[idx].opc;
      req = LerMem || EscMem;
      if (eh_fetch)  mem_pronto = (esperas >= tab[idx].fw);
      else if (req)  mem_pronto = (esperas >= tab[idx].mw);
      else           mem_pronto = r_p();
      if (req) esperas = mem_pronto ? 0 : esperas + 1;
      prev_fw = eh_fetch && !mem_pronto;
      ciclos++;
    end
    if (idx != 9) begin
      n_cmp++; n_bad++;
      $display("FAIL cpi_budget: reached entry %0d of 9", idx);
    end

    // Random programs
    for (int p = 0; p < 40; p++) begin
      do_reset(int'($urandom_range(1, 3)));
      for (int k = 0; k < 15; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 3)      opc = OW'($urandom_range(16, 31));
        else if (r < 6) opc = 5'd15;
        else            opc = OW'($urandom_range(0, 14));
        fw = ($urandom_range(0, 29) == 0) ? 4 : int'($urandom_range(0, 3));
        mw = ($urandom_range(0, 29) == 0) ? 4 : int'($urandom_range(0, 3));
        instr(opc, fw, mw, 4, fim);
        if (fim) break;
      end
      run_q();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
